mvm_byte_engine: RTL and testbench
==================================

# mvm_byte_engine

Parametrised matrix-vector multiply engine with byte-stream input and output. It receives a header, an optional R×C matrix K and a C-element vector x as bytes, computes y = K·x one row per cycle, and streams the R results back as little-endian bytes. It sits between the UART RX deserialiser and the UART TX serialiser in the next-generation MVM UART system. It adds matrix reuse across transactions, signed/unsigned mode and selectable saturation.

## Interface
- R, 8: matrix rows and output vector length.
- C, 8: matrix columns and input vector length.
- W_X, 4: x element width; 1..8.
- W_K, 4: K element width; 1..8.
- W_Y_OUT, 16: output word width; must be a multiple of 8.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  input byte from RX.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  engine accepts s_data this cycle.
- m_data  out  8  output byte to TX.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  TX accepts m_data.
- busy  out  1  high in any state other than IDLE.
- k_loaded  out  1  K holds a complete matrix received since reset.

## Operation
- A beat occurs on the input when s_valid && s_ready. A beat occurs on the output when m_valid && m_ready.
- IDLE:
  - The first beat is the header. Bit0 = load_k. Bit1 = signed mode (latched for the transaction). Bits 7:2 are ignored.
  - Next state is LOAD_K if load_k=1, otherwise LOAD_X.
- LOAD_K:
  - R·C beats, row-major (row 0 col 0 first).
  - Each beat supplies one element in its low W_K bits; upper bits are ignored.
  - After the last element, k_loaded goes to 1 and the state moves to LOAD_X.
- LOAD_X:
  - C beats, element 0 first, in the low W_X bits.
  - After the last beat, the state moves to COMPUTE.
- COMPUTE:
  - Runs for R cycles. In cycle r, y[r] = Σ_c K[r][c]·x[c] and the result is written to the y buffer.
  - Signed mode sign-extends the elements; unsigned mode zero-extends them.
  - Accumulation uses the full width W_X+W_K+$clog2(C)+1, so nothing is lost internally.
- SEND:
  - Outputs R·(W_Y_OUT/8) bytes: row 0 first, least-significant byte first within each word.
  - After the final beat the state returns to IDLE.
- Output narrowing (without the macro): y is truncated to its low W_Y_OUT bits and wraps.
- With load_k=0 the stored K is reused. If no K has been loaded since reset, K is all zeros and all results are 0.
- s_ready is 1 only in IDLE, LOAD_K and LOAD_X. m_valid is 1 only in SEND.

## Timing
- Reset values:
  - State IDLE; element and byte counters 0; K and y buffers 0; signed mode latch 0.
  - Outputs: s_ready=0, m_valid=0, m_data=0, busy=0, k_loaded=0.
  - s_ready rises to 1 on the first cycle after rst deasserts.
- Latency: if the last x beat is accepted at cycle t, COMPUTE occupies cycles t+1..t+R and m_valid first asserts at cycle t+R+1.
- m_data and m_valid are registered. While m_valid=1 && m_ready=0, m_data holds stable.
- Gaps between beats on either side are allowed without limit.
- After the last SEND beat, IDLE and s_ready=1 follow on the next cycle.
- rst asserted in any state (including mid-LOAD_K or mid-SEND) returns all state to reset values at the next edge. Partial data is discarded, k_loaded=0, and m_valid drops without completing.

## Configuration
- MVM_SAT_EN defined:
  - Results are clamped to the W_Y_OUT range before storage.
  - Signed mode range: [−2^(W_Y_OUT−1), 2^(W_Y_OUT−1)−1].
  - Unsigned mode range: [0, 2^W_Y_OUT−1].
- MVM_SAT_EN undefined: results are truncated to the low W_Y_OUT bits, with no clamp logic.

## Test plan
- Defaults, unsigned load: header 0x01, K all 0x1, x all 0xF → 16 bytes 78 00 repeated 8×; k_loaded=1.
- K reuse (follows the previous scenario): header 0x00, x = 0,1,…,7 → each y = 28, bytes 1C 00 ×8; no K bytes consumed.
- Signed: header 0x03, K all 0xF (−1), x all 0x7 → y = −56, bytes C8 FF ×8.
- Backpressure: hold m_ready=0 for 5 cycles mid-SEND → m_data and m_valid stable, s_ready=0, no byte lost or duplicated.
- Narrowing with W_Y_OUT=8: header 0x01, K all 0xF, x all 0xF (sum 1800 = 0x708) → byte 0x08 without MVM_SAT_EN, 0xFF with it.
- Reset mid-operation: pulse rst after 10 K bytes, then send header 0x00 with x all 0x5 → k_loaded=0, eight 00 00 words output.

Source files
------------

// File: rtl/mvm_byte_engine.sv
// mvm_byte_engine
//   Byte-stream matrix-vector multiply engine: y = K * x.
//   A header byte selects whether a new R x C matrix K follows (bit0) and
//   whether elements are signed (bit1). K (optional, row-major) and the
//   C-element vector x arrive one element per byte. One result row is
//   computed per cycle, then the R results stream out as little-endian
//   W_Y_OUT-bit words. K persists across transactions until reset.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   s_data    input byte            s_valid  input byte valid
//   s_ready   engine accepts s_data (IDLE / LOAD_K / LOAD_X)
//   m_data    output byte           m_valid  output byte valid (SEND)
//   m_ready   downstream accepts m_data
//   busy      engine not in IDLE
//   k_loaded  a complete K has been received since reset
//
// Build option
//   MVM_SAT_EN  clamp each result to the W_Y_OUT range of the current mode
//               instead of keeping its low W_Y_OUT bits.

module mvm_byte_engine #(
  parameter int unsigned R       = 8,
  parameter int unsigned C       = 8,
  parameter int unsigned W_X     = 4,
  parameter int unsigned W_K     = 4,
  parameter int unsigned W_Y_OUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       k_loaded
);

  // Accumulator wide enough for C full-precision products.
  localparam int unsigned AW = W_X + W_K + $clog2(C) + 1;
  // Extended width: at least one bit above both AW and W_Y_OUT so the
  // overflow slices below are never empty.
  localparam int unsigned EW = ((AW > W_Y_OUT) ? AW : W_Y_OUT) + 1;
  localparam int unsigned NB = R * (W_Y_OUT / 8);
  localparam int unsigned CW = $clog2(R * C + 1);
  localparam int unsigned BW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_X,
    S_COMPUTE,
    S_SEND
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          byte_q, byte_d;
  logic                   signed_q, signed_d;
  logic                   k_loaded_q, k_loaded_d;
  logic                   s_ready_q, s_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic [7:0]             m_data_q, m_data_d;
  logic [R*C*W_K-1:0]     k_q, k_d;
  logic [C*W_X-1:0]       x_q, x_d;
  logic [R*W_Y_OUT-1:0]   y_q, y_d;

  logic in_beat, out_beat;
  logic last_k, last_x, last_row, last_byte;

  assign in_beat   = s_valid && s_ready_q;
  assign out_beat  = m_valid_q && m_ready;
  assign last_k    = (cnt_q == CW'(R * C - 1));
  assign last_x    = (cnt_q == CW'(C - 1));
  assign last_row  = (cnt_q == CW'(R - 1));
  assign last_byte = (byte_q == BW'(NB - 1));

  // ---------------------------------------------------------------- row MAC
  logic [W_K-1:0]     kv;
  logic [W_X-1:0]     xv;
  logic [AW-1:0]      ke, xe, acc;
  logic [EW-1:0]      acc_ext;
  logic [W_Y_OUT-1:0] y_new;
  int unsigned        row_idx;

  always_comb begin
    row_idx = (cnt_q < CW'(R)) ? 32'(cnt_q) : 32'd0;
    kv  = '0;
    xv  = '0;
    ke  = '0;
    xe  = '0;
    acc = '0;
    // Modular AW-bit arithmetic: the true sum always fits in AW signed bits,
    // so the low AW bits are exact in both modes.
    for (int unsigned c = 0; c < C; c++) begin
      kv  = k_q[(row_idx * C + c) * W_K +: W_K];
      xv  = x_q[c * W_X +: W_X];
      ke  = {{(AW - W_K){signed_q & kv[W_K-1]}}, kv};
      xe  = {{(AW - W_X){signed_q & xv[W_X-1]}}, xv};
      acc = acc + ke * xe;
    end
    acc_ext = {{(EW - AW){signed_q & acc[AW-1]}}, acc};
`ifdef MVM_SAT_EN
    if (signed_q) begin
      // In range only if every bit from the output sign bit upward agrees.
      if (!((&acc_ext[EW-1:W_Y_OUT-1]) || !(|acc_ext[EW-1:W_Y_OUT-1])))
        y_new = acc_ext[EW-1] ? {1'b1, {(W_Y_OUT - 1){1'b0}}}
                              : {1'b0, {(W_Y_OUT - 1){1'b1}}};
      else
        y_new = acc_ext[W_Y_OUT-1:0];
    end else if (|acc_ext[EW-1:W_Y_OUT]) begin
      y_new = '1;
    end else begin
      y_new = acc_ext[W_Y_OUT-1:0];
    end
`else
    y_new = acc_ext[W_Y_OUT-1:0];
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{s_data, acc_ext};

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_beat) state_d = s_data[0] ? S_LOAD_K : S_LOAD_X;
      S_LOAD_K:  if (in_beat && last_k) state_d = S_LOAD_X;
      S_LOAD_X:  if (in_beat && last_x) state_d = S_COMPUTE;
      S_COMPUTE: if (last_row) state_d = S_SEND;
      S_SEND:    if (out_beat && last_byte) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- datapath updates
  always_comb begin
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    signed_d   = signed_q;
    k_loaded_d = k_loaded_q;
    k_d        = k_q;
    x_d        = x_q;
    y_d        = y_q;
    m_data_d   = m_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_beat) begin
          signed_d = s_data[1];
          cnt_d    = '0;
        end
      end
      S_LOAD_K: begin
        if (in_beat) begin
          k_d[32'(cnt_q) * W_K +: W_K] = s_data[W_K-1:0];
          if (last_k) begin
            cnt_d      = '0;
            k_loaded_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_X: begin
        if (in_beat) begin
          x_d[32'(cnt_q) * W_X +: W_X] = s_data[W_X-1:0];
          cnt_d = last_x ? '0 : cnt_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        y_d[row_idx * W_Y_OUT +: W_Y_OUT] = y_new;
        if (last_row) begin
          cnt_d  = '0;
          byte_d = '0;
          // Taken from y_d so the first byte is correct even when R == 1.
          m_data_d = y_d[7:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (out_beat) begin
          if (last_byte) begin
            byte_d   = '0;
            m_data_d = '0;
          end else begin
            byte_d   = byte_q + 1'b1;
            m_data_d = y_q[8 * (32'(byte_q) + 1) +: 8];
          end
        end
      end
      default: ;
    endcase
    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_K) || (state_d == S_LOAD_X);
    m_valid_d = (state_d == S_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      byte_q     <= '0;
      signed_q   <= 1'b0;
      k_loaded_q <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      signed_q   <= signed_d;
      k_loaded_q <= k_loaded_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      k_q        <= k_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    s_ready  = s_ready_q;
    m_valid  = m_valid_q;
    m_data   = m_data_q;
    busy     = (state_q != S_IDLE);
    k_loaded = k_loaded_q;
  end

endmodule

// File: tb/tb_mvm_byte_engine.sv
// Testbench for mvm_byte_engine: a default instance (W_Y_OUT=16) and a
// narrow-output instance (W_Y_OUT=8), checked against an integer model.

module tb_mvm_byte_engine;

  localparam int unsigned R  = 8;
  localparam int unsigned C  = 8;
  localparam int unsigned WX = 4;
  localparam int unsigned WK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data   [2];
  logic       s_valid  [2];
  logic       s_ready  [2];
  logic [7:0] m_data   [2];
  logic       m_valid  [2];
  logic       m_ready  [2];
  logic       busy     [2];
  logic       k_loaded [2];

  always #5 clk = ~clk;

  mvm_byte_engine #(.R(R), .C(C), .W_X(WX), .W_K(WK), .W_Y_OUT(16)) dut16 (
    .clk(clk), .rst(rst),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .busy(busy[0]), .k_loaded(k_loaded[0])
  );

  mvm_byte_engine #(.R(R), .C(C), .W_X(WX), .W_K(WK), .W_Y_OUT(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .busy(busy[1]), .k_loaded(k_loaded[1])
  );

  int           nchk = 0;
  int           nerr = 0;
  int           mk [2][R][C];
  bit           mkl [2];
  int           stim_k [R][C];
  int           stim_x [C];
  byte unsigned q0 [$];
  byte unsigned q1 [$];
  longint       last_w0;

  // ------------------------------------------------------------- model
  function automatic int wy(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic longint ext(input int v, input int w, input bit sgn);
    longint u;
    u = longint'(v) & ((longint'(1) << w) - 1);
    if (sgn && u >= (longint'(1) << (w - 1))) u = u - (longint'(1) << w);
    return u;
  endfunction

  function automatic longint narrow(input longint y, input int w, input bit sgn);
    longint v;
    v = y;
`ifdef MVM_SAT_EN
    begin
      longint lo, hi;
      if (sgn) begin
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
      end else begin
        lo = 0;
        hi = (longint'(1) << w) - 1;
      end
      if (v > hi) v = hi;
      if (v < lo) v = lo;
    end
`endif
    return v & ((longint'(1) << w) - 1);
  endfunction

  function automatic void push_exp(input int d, input byte unsigned b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int peek_exp(input int d);
    if (qsize(d) == 0) return -1;
    return (d == 0) ? int'(q0[0]) : int'(q1[0]);
  endfunction

  function automatic void pop_exp(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- output compare
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d]) begin
          check((d == 0) ? "out_byte_w16" : "out_byte_w8", longint'(m_data[d]),
                longint'(peek_exp(d)));
          check("s_ready_in_send", longint'(s_ready[d]), 0);
          check("busy_in_send", longint'(busy[d]), 1);
          if (m_ready[d] && qsize(d) > 0) pop_exp(d);
        end
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic send_byte(input int d, input logic [7:0] b, input bit gap);
    int t;
    bit ok;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_data[d]  = b;
    s_valid[d] = 1'b1;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (s_ready[d]) ok = 1'b1;
      else            t++;
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: dut %0d did not accept byte %02h", d, b);
    end
    @(posedge clk); #1;
    s_valid[d] = 1'b0;
  endtask

  task automatic run_txn(input int d, input bit load, input bit sgn,
                         input bit bp, input bit gap);
    logic [7:0] h;
    longint     y, yn;
    int         lat, n;
    h    = 8'($urandom);
    h[0] = load;
    h[1] = sgn;
    send_byte(d, h, gap);
    if (load) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          send_byte(d, {4'($urandom), 4'(stim_k[r][c])}, gap);
          mk[d][r][c] = stim_k[r][c];
        end
      mkl[d] = 1'b1;
    end
    for (int r = 0; r < R; r++) begin
      y = 0;
      for (int c = 0; c < C; c++)
        y += ext(mk[d][r][c], WK, sgn) * ext(stim_x[c], WX, sgn);
      yn = narrow(y, wy(d), sgn);
      if (r == 0) last_w0 = yn;
      for (int b = 0; b < wy(d) / 8; b++)
        push_exp(d, 8'((yn >> (8 * b)) & 255));
    end
    for (int c = 0; c < C; c++)
      send_byte(d, {4'($urandom), 4'(stim_x[c])}, gap);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid[d] && lat < 64);
    check("first_m_valid_latency", lat, R + 1);
    n = 0;
    while (qsize(d) > 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (bp && n >= 3 && n < 8) m_ready[d] = 1'b0;
      else                       m_ready[d] = ($urandom_range(0, 3) != 0);
    end
    m_ready[d] = 1'b0;
    if (qsize(d) > 0) begin
      check("drain_bytes_left", qsize(d), 0);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
    @(negedge clk);
    check("idle_s_ready", longint'(s_ready[d]), 1);
    check("idle_busy", longint'(busy[d]), 0);
    check("idle_m_valid", longint'(m_valid[d]), 0);
    check("k_loaded", longint'(k_loaded[d]), longint'(mkl[d]));
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      mkl[d] = 1'b0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) mk[d][r][c] = 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ sequence
  initial begin
    int d;
    for (int i = 0; i < 2; i++) begin
      s_data[i]  = '0;
      s_valid[i] = 1'b0;
      m_ready[i] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_s_ready", longint'(s_ready[i]), 0);
      check("reset_m_valid", longint'(m_valid[i]), 0);
      check("reset_m_data", longint'(m_data[i]), 0);
      check("reset_busy", longint'(busy[i]), 0);
      check("reset_k_loaded", longint'(k_loaded[i]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      check("s_ready_after_reset", longint'(s_ready[i]), 1);

    // Unsigned load: K=1, x=15 -> 120 per row
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) stim_k[r][c] = 1;
    for (int c = 0; c < C; c++) stim_x[c] = 15;
    run_txn(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pin_unsigned_word", last_w0, 'h78);

    // Reuse stored K: x = 0..7 -> 28
    for (int c = 0; c < C; c++) stim_x[c] = c;
    run_txn(0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pin_reuse_word", last_w0, 28);

    // Signed: K=-1, x=7 -> -56
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) stim_k[r][c] = 15;
    for (int c = 0; c < C; c++) stim_x[c] = 7;
    run_txn(0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pin_signed_word", last_w0, 'hFFC8);

    // Backpressure mid-SEND on random data
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) stim_k[r][c] = $urandom_range(0, 15);
    for (int c = 0; c < C; c++) stim_x[c] = $urandom_range(0, 15);
    run_txn(0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);

    // Narrow output: 1800 into 8 bits
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) stim_k[r][c] = 15;
    for (int c = 0; c < C; c++) stim_x[c] = 15;
    run_txn(1, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef MVM_SAT_EN
    check("pin_narrow_word", last_w0, 'hFF);
`else
    check("pin_narrow_word", last_w0, 'h08);
`endif

    // Reset after 10 K bytes discards everything
    send_byte(0, 8'h01, 1'b0);
    repeat (10) send_byte(0, 8'h03, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("midreset_k_loaded", longint'(k_loaded[0]), 0);
    check("midreset_busy", longint'(busy[0]), 0);
    check("midreset_k_loaded_w8", longint'(k_loaded[1]), 0);
    @(posedge clk); #1;
    for (int c = 0; c < C; c++) stim_x[c] = 5;
    run_txn(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pin_zero_k_word", last_w0, 0);

    // Randomised transactions on either instance
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 1);
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) stim_k[r][c] = $urandom_range(0, 15);
      for (int c = 0; c < C; c++) stim_x[c] = $urandom_range(0, 15);
      run_txn(d, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
